// File: rtl/ssd_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with frame-aligned double
// buffering, per-digit blank/dp and PWM brightness within each digit slot.
module ssd_scan_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000
) (
  input  logic                  x1,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     anodes,
  output logic [7:0]            SSD,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned TW = $clog2(17 * DIV) + 1;
  localparam int unsigned VW = 4 * DIGITS;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     pend_val_q, pend_val_d, sh_val_q, sh_val_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d, sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0] pend_blank_q, pend_blank_d, sh_blank_q, sh_blank_d;
  logic              pending_q, pending_d;
  logic [DIGITS-1:0] anodes_q, anodes_d;
  logic [7:0]        ssd_q, ssd_d;
  logic              tick_q, tick_d;

  logic              last_cnt_c, fb_c, copy_c, lit_c, dp_sel_c, blank_sel_c;
  logic [3:0]        nib_c;
  logic [TW-1:0]     thr_c;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Scan counters, buffer transfer and next registered display outputs
  always_comb begin
    last_cnt_c  = (cnt_q == CW'(DIV - 1));
    fb_c        = last_cnt_c && (idx_q == IW'(DIGITS - 1));
    copy_c      = fb_c && pending_q;
    cnt_d       = last_cnt_c ? '0 : cnt_q + CW'(1);
    idx_d       = idx_q;
    if (last_cnt_c) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);

    sh_val_d     = sh_val_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pending_d    = pending_q;
    if (copy_c) begin
      sh_val_d   = pend_val_q;
      sh_dp_d    = pend_dp_q;
      sh_blank_d = pend_blank_q;
      pending_d  = 1'b0;
    end
    // A load in the boundary cycle lands after the copy has taken the old data
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp;
      pend_blank_d = blank;
      pending_d    = 1'b1;
    end
    tick_d = copy_c;

    nib_c       = 4'h0;
    dp_sel_c    = 1'b0;
    blank_sel_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IW'(i)) begin
        nib_c       = sh_val_q[4*i +: 4];
        dp_sel_c    = sh_dp_q[i];
        blank_sel_c = sh_blank_q[i];
      end
    end

    thr_c = TW'((TW'(bright) + TW'(1)) * TW'(DIV)) >> 4;
    lit_c = !blank_sel_c && (TW'(cnt_q) < thr_c);

    for (int i = 0; i < int'(DIGITS); i++) begin
      anodes_d[i] = !(lit_c && (idx_q == IW'(i)));
    end
    ssd_d = lit_c ? {~dp_sel_c, hex7(nib_c)} : 8'hFF;
  end

  always_ff @(posedge x1) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pending_q    <= 1'b0;
      sh_val_q     <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      anodes_q     <= '1;
      ssd_q        <= 8'hFF;
      tick_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pending_q    <= pending_d;
      sh_val_q     <= sh_val_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      anodes_q     <= anodes_d;
      ssd_q        <= ssd_d;
      tick_q       <= tick_d;
    end
  end

  assign anodes     = anodes_q;
  assign SSD        = ssd_q;
  assign pending    = pending_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl (DIGITS=4, DIV=16): directed scenarios plus random
// loads/brightness/resets, checked each cycle against a frame-arithmetic model.
module tb_ssd_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 16;
  localparam int FRAME  = DIGITS * DIV;

  logic        x1 = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp, blank;
  logic        load;
  logic [3:0]  bright;
  logic [3:0]  anodes;
  logic [7:0]  SSD;
  logic        pending, frame_tick;

  ssd_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .x1(x1), .rst(rst), .value(value), .dp(dp), .blank(blank), .load(load),
    .bright(bright), .anodes(anodes), .SSD(SSD), .pending(pending),
    .frame_tick(frame_tick)
  );

  always #5 x1 = ~x1;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int checks = 0;
  int passes = 0;

  // Model: k = cycles elapsed since reset release; slot/digit follow by division
  int          k;
  logic [15:0] m_pv, m_sv;
  logic [3:0]  m_pd, m_pb, m_sd, m_sb;
  bit          m_pend;
  logic [3:0]  e_an;
  logic [7:0]  e_ssd;
  bit          e_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
  endtask

  task automatic tick();
    int c, d, thr;
    bit lit;
    if (rst) begin
      e_an = 4'hF; e_ssd = 8'hFF; e_tick = 0;
      m_pv = '0; m_sv = '0; m_pd = '0; m_pb = '0; m_sd = '0; m_sb = '0;
      m_pend = 0; k = 0;
    end else begin
      c   = k % DIV;
      d   = (k / DIV) % DIGITS;
      thr = ((int'(bright) + 1) * DIV) / 16;
      lit = !m_sb[d] && (c < thr);
      e_an  = lit ? ~(4'b0001 << d) : 4'hF;
      e_ssd = lit ? {~m_sd[d], hex_tab[m_sv[4*d +: 4]][6:0]} : 8'hFF;
      e_tick = ((k % FRAME) == FRAME - 1) && m_pend;
      if (e_tick) begin
        m_sv = m_pv; m_sd = m_pd; m_sb = m_pb; m_pend = 0;
      end
      if (load) begin
        m_pv = value; m_pd = dp; m_pb = blank; m_pend = 1;
      end
      k++;
    end
    @(posedge x1);
    #1;
    chk("anodes", 32'(anodes), 32'(e_an));
    chk("ssd", 32'(SSD), 32'(e_ssd));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("frame_tick", 32'(frame_tick), 32'(e_tick));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p, input logic [3:0] b);
    value = v; dp = p; blank = b; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < FRAME && (k % FRAME) != phase; i++) tick();
  endtask

  initial begin
    rst = 1'b1; value = '0; dp = '0; blank = '0; load = 1'b0; bright = 4'd15;
    k = 0;
    // Reset held two cycles, then first lit digit 0 showing 0
    run(2);
    chk("rst_anodes", 32'(anodes), 32'h0000000F);
    chk("rst_ssd", 32'(SSD), 32'h000000FF);
    rst = 1'b0;
    tick();
    chk("first_anodes", 32'(anodes), 32'h0000000E);
    chk("first_ssd", 32'(SSD), 32'h000000C0);

    // Buffered load at cycle 5, shown from the next frame
    run(4);
    do_load(16'h1234, 4'h0, 4'h0);
    chk("pend_after_load", 32'(pending), 32'h1);
    run_to(FRAME - 1);
    tick();
    chk("tick_at_fb", 32'(frame_tick), 32'h1);
    tick();
    chk("digit0_1234", 32'(SSD), 32'h00000099);
    run(FRAME + 10);

    // Brightness extremes
    bright = 4'd3;  run(FRAME);
    bright = 4'd0;  run(FRAME);
    bright = 4'd9;  run(FRAME);
    bright = 4'd15;

    // Blank and decimal point
    do_load(16'h1234, 4'b0001, 4'b0100);
    run_to(FRAME - 1);
    run(2);
    chk("digit0_dp", 32'(SSD), 32'h00000019);
    run(FRAME);

    // Two loads before a boundary: latest wins
    do_load(16'hAAAA, 4'h0, 4'h0);
    run(3);
    do_load(16'h5555, 4'h0, 4'h0);
    run_to(FRAME - 1);
    run(FRAME + 2);

    // Load exactly in the boundary cycle
    do_load(16'h9876, 4'hA, 4'h0);
    run_to(FRAME - 1);
    do_load(16'hFEDC, 4'h5, 4'h2);
    chk("fb_load_pend", 32'(pending), 32'h1);
    chk("fb_load_tick", 32'(frame_tick), 32'h1);
    run(FRAME);
    run(FRAME + 2);

    // Reset mid-frame at digit 2, count 7
    do_load(16'h1234, 4'h0, 4'h0);
    run_to(FRAME - 1);
    run(FRAME);
    run_to(2 * DIV + 7);
    rst = 1'b1; tick();
    chk("midrst_anodes", 32'(anodes), 32'h0000000F);
    rst = 1'b0; tick();
    chk("midrst_ssd", 32'(SSD), 32'h000000C0);
    run(FRAME);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        value = 16'($urandom); dp = 4'($urandom); blank = 4'($urandom); load = 1'b1;
      end else load = 1'b0;
      if ($urandom_range(0, 49) == 0) bright = 4'($urandom);
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    load = 1'b0; rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
